mutex_arbiter_n: RTL and testbench

- Parametrised N-channel mutual-exclusion arbiter with registered one-hot grants and a request/hold/release handshake.
- Successor to the fixed 4-way combinational mutex.
- Adds three features:
  - selectable fixed-priority or round-robin arbitration;
  - a guaranteed one-cycle dead gap between owners;
  - an optional hold-timeout that forcibly revokes a grant.
- Sits between N requesters and one shared resource (bus, memory port, log buffer).

---
 rtl/mutex_arbiter_n.sv | 151 +++++++++++++++
 tb/tb_mutex_arbiter_n.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mutex_arbiter_n.sv
// N-channel mutual-exclusion arbiter: registered one-hot grant, one-cycle dead
// gap between owners, fixed-priority or round-robin pick, optional hold timeout.

module mutex_arbiter_lane (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic set_lock,
  output logic cand
);
  logic lock_q, lock_d;

  // A timed-out channel stays excluded until it drops req for a cycle.
  always_comb lock_d = (lock_q & req) | set_lock;

  always_ff @(posedge clk) begin
    if (rst) lock_q <= 1'b0;
    else     lock_q <= lock_d;
  end

  assign cand = req & ~lock_q;
endmodule

module mutex_arbiter_n #(
  parameter int N        = 4,
  parameter int MODE     = 0,
  parameter int HOLD_MAX = 0,
  parameter int CNT_W    = 8,
  parameter int ID_W     = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id,
  output logic            busy,
  output logic            timeout
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX > 0 ? HOLD_MAX - 1 : 0);

  logic [1:0]       state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  logic [N-1:0]     cand, set_lock;
  logic [2*N-1:0]   dbl;
  logic [N-1:0]     rot;
  logic [ID_W-1:0]  win;
  logic             found;
  int               off;
  logic             owner_req;

  for (genvar i = 0; i < N; i++) begin : g_lane
    mutex_arbiter_lane u_lane (
      .clk      (clk),
      .rst      (rst),
      .req      (req[i]),
      .set_lock (set_lock[i]),
      .cand     (cand[i])
    );
  end

  // Round-robin: rotate candidates so the pointer sits at bit 0, take lowest.
  always_comb begin
    win   = '0;
    found = 1'b0;
    off   = 0;
    dbl   = {cand, cand} >> ptr_q;
    rot   = dbl[N-1:0];
    if (MODE == 0) begin
      for (int i = 0; i < N; i++)
        if (cand[i]) begin win = ID_W'(i); found = 1'b1; end
    end else begin
      for (int k = N - 1; k >= 0; k--)
        if (rot[k]) begin off = k; found = 1'b1; end
      win = ID_W'((int'(ptr_q) + off) % N);
    end
  end

  assign owner_req = |(req & grant_q);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    set_lock  = '0;
    case (state_q)
      ST_IDLE: if (found) begin
        grant_d = N'(1) << win;
        id_d    = win;
        cnt_d   = '0;
        state_d = ST_OWN;
        if (MODE == 1) ptr_d = ID_W'((int'(win) + 1) % N);
      end
      ST_OWN: begin
        // Release wins over a coincident timeout.
        if (!owner_req) begin
          grant_d = '0;
          id_d    = '0;
          state_d = ST_GAP;
        end else if (HOLD_MAX > 0 && cnt_q == HOLD_LAST) begin
          grant_d   = '0;
          id_d      = '0;
          timeout_d = 1'b1;
          set_lock  = grant_q;
          state_d   = ST_GAP;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        id_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      id_q      <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      id_q      <= id_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = id_q;
  assign busy     = |grant_q;
  assign timeout  = timeout_q;
endmodule

// File: tb/tb_mutex_arbiter_n.sv
// Three arbiters (fixed-priority, round-robin, fixed-priority with HOLD_MAX=5)
// compared every cycle against a per-instance behavioural model.

module tb_mutex_arbiter_n;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req_a = '0, req_b = '0, req_c = '0;
  logic [3:0] gnt_a, gnt_b, gnt_c;
  logic [1:0] id_a, id_b, id_c;
  logic busy_a, busy_b, busy_c, to_a, to_b, to_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mutex_arbiter_n #(.N(4), .MODE(0), .HOLD_MAX(0), .CNT_W(8), .ID_W(2)) u_fp (
    .clk(clk), .rst(rst), .req(req_a), .grant(gnt_a), .grant_id(id_a),
    .busy(busy_a), .timeout(to_a));
  mutex_arbiter_n #(.N(4), .MODE(1), .HOLD_MAX(0), .CNT_W(8), .ID_W(2)) u_rr (
    .clk(clk), .rst(rst), .req(req_b), .grant(gnt_b), .grant_id(id_b),
    .busy(busy_b), .timeout(to_b));
  mutex_arbiter_n #(.N(4), .MODE(0), .HOLD_MAX(5), .CNT_W(8), .ID_W(2)) u_to (
    .clk(clk), .rst(rst), .req(req_c), .grant(gnt_c), .grant_id(id_c),
    .busy(busy_c), .timeout(to_c));

  int         mode_p[3] = '{0, 1, 0};
  int         hmax_p[3] = '{0, 0, 5};
  int         m_own[3];
  bit         m_gap[3];
  int         m_cnt[3];
  int         m_ptr[3];
  logic [3:0] m_lock[3];
  bit         m_to[3];
  logic [3:0] prev_g[3];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Owner is an index or -1; gap is the single dead cycle after any loss of ownership.
  task automatic model_step(int c, logic [3:0] r, logic rs);
    logic [3:0] nl, cand;
    int w;
    if (rs) begin
      m_own[c] = -1; m_gap[c] = 0; m_cnt[c] = 0; m_ptr[c] = 0;
      m_lock[c] = '0; m_to[c] = 0;
      return;
    end
    nl = m_lock[c] & r;
    m_to[c] = 0;
    if (m_gap[c]) begin
      m_gap[c] = 0;
    end else if (m_own[c] >= 0) begin
      if (!r[m_own[c]]) begin
        m_own[c] = -1; m_gap[c] = 1;
      end else if (hmax_p[c] > 0 && m_cnt[c] == hmax_p[c] - 1) begin
        nl[m_own[c]] = 1'b1; m_to[c] = 1; m_own[c] = -1; m_gap[c] = 1;
      end else if (m_cnt[c] < 255) begin
        m_cnt[c]++;
      end
    end else begin
      cand = r & ~m_lock[c];
      w = -1;
      if (mode_p[c] == 0) begin
        for (int i = 0; i < 4; i++) if (cand[i]) w = i;
      end else begin
        for (int k = 3; k >= 0; k--) if (cand[(m_ptr[c] + k) % 4]) w = (m_ptr[c] + k) % 4;
      end
      if (w >= 0) begin
        m_own[c] = w; m_cnt[c] = 0;
        if (mode_p[c] == 1) m_ptr[c] = (w + 1) % 4;
      end
    end
    m_lock[c] = nl;
  endtask

  task automatic tick();
    logic [3:0] r[3], g[3], eg;
    logic [1:0] id[3];
    logic b[3], t[3];
    @(posedge clk);
    r[0] = req_a; r[1] = req_b; r[2] = req_c;
    for (int c = 0; c < 3; c++) model_step(c, r[c], rst);
    #1;
    g[0] = gnt_a;  g[1] = gnt_b;  g[2] = gnt_c;
    id[0] = id_a;  id[1] = id_b;  id[2] = id_c;
    b[0] = busy_a; b[1] = busy_b; b[2] = busy_c;
    t[0] = to_a;   t[1] = to_b;   t[2] = to_c;
    for (int c = 0; c < 3; c++) begin
      eg = (m_own[c] >= 0) ? 4'(1 << m_own[c]) : 4'b0000;
      check($sformatf("grant[%0d]", c), 32'(g[c]), 32'(eg));
      check($sformatf("grant_id[%0d]", c), 32'(id[c]), (m_own[c] >= 0) ? m_own[c] : 0);
      check($sformatf("busy[%0d]", c), 32'(b[c]), 32'(m_own[c] >= 0));
      check($sformatf("timeout[%0d]", c), 32'(t[c]), 32'(m_to[c]));
      check($sformatf("onehot0[%0d]", c), 32'($onehot0(g[c])), 1);
      check($sformatf("busy_or[%0d]", c), 32'(b[c]), 32'(|g[c]));
      check($sformatf("adjacent_owner[%0d]", c),
            32'(prev_g[c] != 0 && g[c] != 0 && g[c] != prev_g[c]), 0);
      prev_g[c] = g[c];
    end
  endtask

  initial begin
    logic [3:0] seq[$];
    logic [3:0] last;
    int hold, gcnt, tcnt;
    for (int c = 0; c < 3; c++) begin
      m_own[c] = -1; m_gap[c] = 0; m_cnt[c] = 0; m_ptr[c] = 0;
      m_lock[c] = '0; m_to[c] = 0; prev_g[c] = '0;
    end

    // Reset then idle.
    rst = 1'b1; tick(); tick();
    rst = 1'b0;
    repeat (5) tick();

    // Fixed priority: highest index wins, release then gap.
    req_a = 4'b1011; tick();
    check("fp_first", 32'(gnt_a), 32'h8);
    tick();
    req_a = 4'b0011; tick();
    check("fp_release", 32'(gnt_a), 32'h0);
    tick();
    check("fp_gap", 32'(gnt_a), 32'h0);
    tick();
    check("fp_next", 32'(gnt_a), 32'h2);
    req_a = 4'b0000; repeat (3) tick();

    // Round-robin rotation with wrap.
    req_b = 4'hF; last = '0; hold = 0;
    repeat (40) begin
      tick();
      if (gnt_b != 0) begin
        if (gnt_b != last) begin seq.push_back(gnt_b); last = gnt_b; hold = 0; end
        hold++;
        req_b = (hold == 3) ? (4'hF & ~gnt_b) : 4'hF;
      end else begin
        last = '0;
        req_b = 4'hF;
      end
    end
    check("rr_count", 32'(seq.size() >= 5), 1);
    if (seq.size() >= 5) begin
      check("rr_seq0", 32'(seq[0]), 32'h1);
      check("rr_seq1", 32'(seq[1]), 32'h2);
      check("rr_seq2", 32'(seq[2]), 32'h4);
      check("rr_seq3", 32'(seq[3]), 32'h8);
      check("rr_seq4", 32'(seq[4]), 32'h1);
    end
    req_b = 4'b0000; repeat (3) tick();

    // Hold timeout and lock.
    req_c = 4'b0100; gcnt = 0; tcnt = 0;
    repeat (20) begin
      tick();
      if (gnt_c != 0) gcnt++;
      if (to_c) tcnt++;
    end
    check("to_grant_cycles", gcnt, 5);
    check("to_pulses", tcnt, 1);
    req_c = 4'b0000; tick();
    req_c = 4'b0100; tick();
    check("to_regrant", 32'(gnt_c), 32'h4);

    // Release on the timeout edge: release wins.
    repeat (4) tick();
    req_c = 4'b0000; tick();
    check("rel_vs_to_timeout", 32'(to_c), 0);
    check("rel_vs_to_grant", 32'(gnt_c), 0);
    tick();
    req_c = 4'b0100; tick();
    check("rel_vs_to_regrant", 32'(gnt_c), 32'h4);
    req_c = 4'b0000; repeat (3) tick();

    // Reset mid-grant; rr pointer restarts at 0.
    req_a = 4'b0010; req_b = 4'b0010; tick();
    check("rst_pre_a", 32'(gnt_a), 32'h2);
    check("rst_pre_b", 32'(gnt_b), 32'h2);
    rst = 1'b1; tick();
    check("rst_drop_a", 32'(gnt_a), 32'h0);
    check("rst_drop_b", 32'(gnt_b), 32'h0);
    rst = 1'b0; req_b = 4'b0101; tick();
    check("rst_regrant_a", 32'(gnt_a), 32'h2);
    check("rst_ptr_b", 32'(gnt_b), 32'h1);

    // Randomized phase: sticky requests with sparse flips and rare resets.
    repeat (500) begin
      req_a ^= 4'($urandom) & 4'($urandom) & 4'($urandom);
      req_b ^= 4'($urandom) & 4'($urandom) & 4'($urandom);
      req_c ^= 4'($urandom) & 4'($urandom) & 4'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
